// File: rtl/mbr_fetch_unit_if.sv
// Byte-read memory handshake between the MBR fetch stage (master) and memory (slave).
interface mbr_fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_data;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_data
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_data
  );
endinterface

// File: rtl/mbr_fetch_unit.sv
// Instruction-byte fetch stage: issues byte reads for MIR fetch requests, loads MBR,
// queues one extra request, and stalls the sequencer while anything is outstanding.
module mbr_fetch_unit #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_i,
  input  logic [ADDR_W-1:0] pc_i,
  mbr_fetch_unit_if.master  mem,
  output logic [7:0]        mbr_o,
  output logic [31:0]       mbru_o,
  output logic [31:0]       mbrs_o,
  output logic              mbr_valid_o,
  output logic              stall_o,
  output logic              err_ovf_o,
  output logic              err_tmo_o
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        mbr_q, mbr_d;
  logic              mbr_valid_q, mbr_valid_d;
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_ovf_q, err_ovf_d;
  logic              err_tmo_q, err_tmo_d;
  logic              tmo_hit;

  // Abort fires on the edge where the counter already sits at T-1 and ack is still absent.
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    // NOTE: every next-state variable takes its current value first so no path infers a latch.
    state_d      = state_q;
    addr_d       = addr_q;
    mbr_d        = mbr_q;
    mbr_valid_d  = mbr_valid_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    cnt_d        = cnt_q;
    err_ovf_d    = err_ovf_q;
    err_tmo_d    = err_tmo_q;

    if (state_q == S_IDLE) begin
      if (fetch_i) begin
        state_d     = S_BUSY;
        addr_d      = pc_i;
        mbr_valid_d = 1'b0;
        cnt_d       = '0;
      end
    end else if (mem.mem_ack) begin
      mbr_d = mem.mem_data;
      cnt_d = '0;
      if (pend_valid_q) begin
        addr_d       = pend_addr_q;
        pend_valid_d = fetch_i;
        if (fetch_i) pend_addr_d = pc_i;
      end else if (fetch_i) begin
        addr_d = pc_i;
      end else begin
        state_d     = S_IDLE;
        mbr_valid_d = 1'b1;
      end
    end else if (tmo_hit) begin
      // A fetch arriving in the abort cycle is deliberately dropped along with the slot.
      state_d      = S_IDLE;
      pend_valid_d = 1'b0;
      mbr_valid_d  = 1'b0;
      err_tmo_d    = 1'b1;
      cnt_d        = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
      if (fetch_i) begin
        if (!pend_valid_q) begin
          pend_valid_d = 1'b1;
          pend_addr_d  = pc_i;
        end else begin
          err_ovf_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and clears every register, so rst dominates all inputs.
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      mbr_q        <= '0;
      mbr_valid_q  <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      cnt_q        <= '0;
      err_ovf_q    <= 1'b0;
      err_tmo_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep all registers updating together on the edge.
      state_q      <= state_d;
      addr_q       <= addr_d;
      mbr_q        <= mbr_d;
      mbr_valid_q  <= mbr_valid_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      cnt_q        <= cnt_d;
      err_ovf_q    <= err_ovf_d;
      err_tmo_q    <= err_tmo_d;
    end
  end

  assign mem.mem_req  = (state_q == S_BUSY);
  assign mem.mem_addr = addr_q;
  assign mbr_o        = mbr_q;
  assign mbru_o       = {24'b0, mbr_q};
  assign mbrs_o       = {{24{mbr_q[7]}}, mbr_q};
  assign mbr_valid_o  = mbr_valid_q;
  assign stall_o      = (state_q == S_BUSY) || pend_valid_q;
  assign err_ovf_o    = err_ovf_q;
  assign err_tmo_o    = err_tmo_q;

endmodule
